// File: rtl/num_tx_pkg.sv
// Shared types, ASCII constants and digit mapping for the integer-to-text transmitter.
// Latency: none (types and combinational helper only).
// Backpressure: not applicable.
package num_tx_pkg;

  typedef enum logic [1:0] {
    RADIX_DEC = 2'd0,
    RADIX_HEX = 2'd1,
    RADIX_OCT = 2'd2,
    RADIX_BIN = 2'd3
  } radix_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    EMIT    = 2'd2
  } state_e;

  localparam logic [7:0] CH_ZERO    = 8'h30;
  localparam logic [7:0] CH_A_LOWER = 8'h61;
  localparam logic [7:0] CH_MINUS   = 8'h2D;

  // Map a digit value 0..15 to its lowercase ASCII character.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    if (d < 4'd10) begin
      return CH_ZERO + {4'd0, d};
    end
    return CH_A_LOWER + {4'd0, d - 4'd10};
  endfunction

endpackage

// File: rtl/num_tx_digit_step.sv
// One radix-conversion step: peels the least significant digit off a magnitude.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module num_tx_digit_step
  import num_tx_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_mag,
  input  logic [1:0]       i_radix,
  output logic [WIDTH-1:0] o_next_mag,
  output logic [7:0]       o_digit_char
);

  logic [3:0] w_digit;

  // Select divide/modulo per radix; power-of-two radices reduce to shift and mask.
  always_comb begin
    o_next_mag = i_mag;
    w_digit    = 4'd0;
    case (radix_e'(i_radix))
      RADIX_DEC: begin
        o_next_mag = i_mag / WIDTH'(10);
        w_digit    = 4'(i_mag % WIDTH'(10));
      end
      RADIX_HEX: begin
        o_next_mag = i_mag >> 4;
        w_digit    = i_mag[3:0];
      end
      RADIX_OCT: begin
        o_next_mag = i_mag >> 3;
        w_digit    = {1'b0, i_mag[2:0]};
      end
      default: begin
        o_next_mag = i_mag >> 1;
        w_digit    = {3'b000, i_mag[0]};
      end
    endcase
  end

  assign o_digit_char = digit_to_ascii(w_digit);

endmodule

// File: rtl/num_to_ascii_tx.sv
// Integer-to-ASCII transmitter (dec/hex/oct/bin); optional zero padding via NUM_TX_ZERO_PAD_EN.
// Latency: D digit cycles (+1 for '-') after accept, then one character per cycle.
// Backpressure: out_ready stalls EMIT with char/last held; in_ready only high in IDLE, no queueing.
module num_to_ascii_tx
  import num_tx_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int MAX_CHARS = WIDTH + 1,
  localparam int CW        = $clog2(MAX_CHARS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic [1:0]       in_radix,
  input  logic             in_signed,
`ifdef NUM_TX_ZERO_PAD_EN
  input  logic [CW-1:0]    in_min_digits,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last
);

  localparam int IW = $clog2(MAX_CHARS);

  state_e           r_state;
  radix_e           r_radix;
  logic             r_neg;
  logic             r_sign_step;
  logic             r_live;
  logic [WIDTH-1:0] r_mag;
  logic [IW-1:0]    r_cnt;
  logic [IW-1:0]    r_idx;
  logic [7:0]       r_buf [MAX_CHARS];

  logic             w_accept;
  logic             w_neg_in;
  logic [WIDTH-1:0] w_mag_in;
  logic [WIDTH-1:0] w_next_mag;
  logic [7:0]       w_digit_char;
  logic             w_pad_more;
  logic             w_digits_done;

  // r_live keeps in_ready low while reset is asserted even though the state is IDLE.
  assign in_ready  = r_live && (r_state == IDLE);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == EMIT);
  assign out_char  = out_valid ? r_buf[r_idx] : 8'h00;
  assign out_last  = out_valid && (r_idx == '0);

  // Negation in WIDTH bits gives the exact unsigned magnitude, including the most-negative value.
  assign w_neg_in = (radix_e'(in_radix) == RADIX_DEC) && in_signed && in_value[WIDTH-1];
  assign w_mag_in = w_neg_in ? (-in_value) : in_value;

  num_tx_digit_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_mag        (r_mag),
    .i_radix      (r_radix),
    .o_next_mag   (w_next_mag),
    .o_digit_char (w_digit_char)
  );

`ifdef NUM_TX_ZERO_PAD_EN
  logic [CW-1:0] r_min;
  logic [CW-1:0] w_min_clamped;

  assign w_min_clamped = (in_min_digits > CW'(WIDTH)) ? CW'(WIDTH) : in_min_digits;
  // Once the magnitude is zero the step keeps producing '0', so padding is just "keep going".
  assign w_pad_more    = (({1'b0, r_cnt} + CW'(1)) < r_min);

  // Capture the minimum digit count with the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= '0;
    end else if (w_accept) begin
      r_min <= w_min_clamped;
    end
  end
`else
  assign w_pad_more = 1'b0;
`endif

  assign w_digits_done = (w_next_mag == '0) && !w_pad_more;

  // Main FSM: accept request, build digits LSB-first into the buffer, then replay MSB-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_radix     <= RADIX_DEC;
      r_neg       <= 1'b0;
      r_sign_step <= 1'b0;
      r_live      <= 1'b0;
      r_mag       <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      for (int i = 0; i < MAX_CHARS; i++) begin
        r_buf[i] <= 8'h00;
      end
    end else begin
      r_live <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_radix     <= radix_e'(in_radix);
            r_mag       <= w_mag_in;
            r_neg       <= w_neg_in;
            r_sign_step <= 1'b0;
            r_cnt       <= '0;
            r_state     <= CONVERT;
          end
        end
        CONVERT: begin
          if (r_sign_step) begin
            // Sign sits above the most significant digit so it is emitted first.
            r_buf[r_cnt] <= CH_MINUS;
            r_idx        <= r_cnt;
            r_cnt        <= r_cnt + 1'b1;
            r_sign_step  <= 1'b0;
            r_state      <= EMIT;
          end else begin
            r_buf[r_cnt] <= w_digit_char;
            r_cnt        <= r_cnt + 1'b1;
            r_mag        <= w_next_mag;
            if (w_digits_done) begin
              if (r_neg) begin
                r_sign_step <= 1'b1;
              end else begin
                r_idx   <= r_cnt;
                r_state <= EMIT;
              end
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (r_idx == '0) begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_idx <= r_idx - 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_num_to_ascii_tx.sv
// Directed bench for num_to_ascii_tx with an expected-character scoreboard.
// Latency: checks first out_valid cycle against digit count (+1 for sign).
// Backpressure: exercises out_ready toggling and held in_valid while busy.
module tb_num_to_ascii_tx;
  import num_tx_pkg::*;

  localparam int WIDTH     = 32;
  localparam int MAX_CHARS = WIDTH + 1;
  localparam int CW        = $clog2(MAX_CHARS) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;
  logic [1:0]       in_radix;
  logic             in_signed;
`ifdef NUM_TX_ZERO_PAD_EN
  logic [CW-1:0]    in_min_digits;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_char;
  logic             out_last;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] c;
    logic       l;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  num_to_ascii_tx #(
    .WIDTH     (WIDTH),
    .MAX_CHARS (MAX_CHARS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_value      (in_value),
    .in_radix      (in_radix),
    .in_signed     (in_signed),
`ifdef NUM_TX_ZERO_PAD_EN
    .in_min_digits (in_min_digits),
`endif
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_char      (out_char),
    .out_last      (out_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Issue one request, push its expected characters, then drain and score the output.
  // abort_after > 0 returns right after that many characters were accepted.
  task automatic run_req(input logic [31:0] val, input logic [1:0] rad, input logic sgn,
                         input string s, input bit tog_mode, input bit hold_v,
                         input int exp_lat, input int abort_after);
    int lat, nt, guard;
    bit first, held, tog, aborted;
    logic [7:0] hc;
    logic hl;
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.c = s[i];
      e.l = (i == s.len() - 1);
      sb.push_back(e);
    end
    @(negedge clk);
    chk("in_ready_before_req", in_ready, 1'b1);
    in_valid  = 1'b1;
    in_value  = val;
    in_radix  = rad;
    in_signed = sgn;
    @(negedge clk);
    if (!hold_v) in_valid = 1'b0;
    lat = 1; nt = 0; guard = 0;
    first = 1'b1; held = 1'b0; tog = 1'b1; aborted = 1'b0;
    hc = 8'h00; hl = 1'b0;
    while (sb.size() > 0 && guard < 500) begin
      if (out_valid) begin
        if (first) begin
          chk("first_valid_latency", lat, exp_lat);
          first = 1'b0;
        end
        if (held) begin
          chk("held_char", out_char, hc);
          chk("held_last", out_last, hl);
        end
        chk("char", out_char, sb[0].c);
        chk("last", out_last, sb[0].l);
        if (hold_v) chk("in_ready_busy", in_ready, 1'b0);
        if (tog_mode) tog = ~tog;
        out_ready = tog_mode ? tog : 1'b1;
        if (out_ready) begin
          void'(sb.pop_front());
          nt++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hc = out_char;
          hl = out_last;
        end
      end else begin
        if (held) chk("held_valid", out_valid, 1'b1);
        held = 1'b0;
        out_ready = 1'b0;
      end
      @(negedge clk);
      lat++;
      guard++;
      if (abort_after > 0 && nt == abort_after) begin
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      chk("all_chars_seen", sb.size(), 0);
      out_ready = 1'b0;
      chk("out_valid_after_last", out_valid, 1'b0);
      chk("in_ready_after_last", in_ready, 1'b1);
      in_valid = 1'b0;
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    string ones;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_value  = '0;
    in_radix  = 2'd0;
    in_signed = 1'b0;
    out_ready = 1'b0;
`ifdef NUM_TX_ZERO_PAD_EN
    in_min_digits = '0;
`endif
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_char", out_char, 8'h00);
    chk("rst_out_last", out_last, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_release", in_ready, 1'b1);

    run_req(32'd12345, 2'd0, 1'b1, "12345", 1'b0, 1'b0, 6, 0);
    run_req(32'h8000_0000, 2'd0, 1'b1, "-2147483648", 1'b0, 1'b0, 12, 0);
    run_req(32'h8000_0000, 2'd0, 1'b0, "2147483648", 1'b0, 1'b0, 11, 0);
    run_req(-32'sd42, 2'd0, 1'b1, "-42", 1'b0, 1'b0, 4, 0);
    run_req(32'h0000_BEEF, 2'd1, 1'b0, "beef", 1'b0, 1'b0, 5, 0);
    run_req(32'hFFFF_FFFF, 2'd1, 1'b1, "ffffffff", 1'b0, 1'b0, 9, 0);
    run_req(32'd8, 2'd2, 1'b0, "10", 1'b0, 1'b0, 3, 0);
    run_req(32'd5, 2'd3, 1'b0, "101", 1'b0, 1'b0, 4, 0);
    ones = "";
    for (int i = 0; i < 32; i++) ones = {ones, "1"};
    run_req(32'hFFFF_FFFF, 2'd3, 1'b0, ones, 1'b0, 1'b0, 33, 0);
    for (int r = 0; r < 4; r++) begin
      run_req(32'd0, 2'(r), 1'b1, "0", 1'b0, 1'b0, 2, 0);
    end
    run_req(32'd987, 2'd0, 1'b0, "987", 1'b1, 1'b1, 4, 0);

    // Abandon "12345" after '2' has been taken.
    run_req(32'd12345, 2'd0, 1'b0, "12345", 1'b0, 1'b0, 6, 2);
    rst_n     = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_char", out_char, 8'h00);
    chk("midrst_out_last", out_last, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_release", in_ready, 1'b1);
    chk("midrst_no_stale_valid", out_valid, 1'b0);
    run_req(32'd7, 2'd0, 1'b0, "7", 1'b0, 1'b0, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
